// File: rtl/cpu_controller.sv
// rtl/cpu_controller.sv - T1..T6 ring sequencer and control-word decoder for the 4-bit CPU
module cpu_controller #(
  parameter bit FAST_NOP = 1'b0
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [3:0] opcode,
  input  logic       zero_flag,
  output logic [5:0] tstate,
  output logic       Cp,
  output logic       Ep,
  output logic       Lp,
  output logic       Lm,
  output logic       Ce,
  output logic       Li,
  output logic       Ei,
  output logic       La,
  output logic       Ea,
  output logic       Su,
  output logic       Eu,
  output logic       Lb,
  output logic       Lo,
  output logic       halted
);

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } tstate_e;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_JMP = 4'b0011;
  localparam logic [3:0] OP_JZ  = 4'b0100;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  tstate_e state_q, state_d;
  logic    halted_q, halted_d;
  logic    uses_t5;

  // Only LDA, ADD and SUB have work past T4; everything else may retire early.
  assign uses_t5 = (opcode == OP_LDA) || (opcode == OP_ADD) || (opcode == OP_SUB);

  // Next ring position; HLT freezes the ring on T4 and nothing moves it afterwards.
  always_comb begin
    state_d  = state_q;
    halted_d = halted_q;
    if (!halted_q) begin
      case (state_q)
        T1: state_d = T2;
        T2: state_d = T3;
        T3: state_d = T4;
        T4: begin
          if (opcode == OP_HLT) begin
            halted_d = 1'b1;
          end else if (FAST_NOP && !uses_t5) begin
            state_d = T1;
          end else begin
            state_d = T5;
          end
        end
        T5: state_d = (FAST_NOP && (opcode == OP_LDA)) ? T1 : T6;
        T6: state_d = T1;
        default: state_d = T1;
      endcase
    end
  end

  // Ring counter and sticky halt flag, both cleared asynchronously by clr.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q  <= T1;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
    end
  end

  // Control word: fetch is opcode-independent, execute decodes opcode only in T4..T6.
  always_comb begin
    Cp = 1'b0; Ep = 1'b0; Lp = 1'b0; Lm = 1'b0; Ce = 1'b0; Li = 1'b0; Ei = 1'b0;
    La = 1'b0; Ea = 1'b0; Su = 1'b0; Eu = 1'b0; Lb = 1'b0; Lo = 1'b0;
    if (!clr && !halted_q) begin
      case (state_q)
        T1: begin Ep = 1'b1; Lm = 1'b1; end
        T2: Cp = 1'b1;
        T3: begin Ce = 1'b1; Li = 1'b1; end
        T4: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB: begin Ei = 1'b1; Lm = 1'b1; end
            OP_JMP: begin Ei = 1'b1; Lp = 1'b1; end
            OP_JZ:  begin Ei = zero_flag; Lp = zero_flag; end
            OP_OUT: begin Ea = 1'b1; Lo = 1'b1; end
            default: ;
          endcase
        end
        T5: begin
          case (opcode)
            OP_LDA: begin Ce = 1'b1; La = 1'b1; end
            OP_ADD, OP_SUB: begin Ce = 1'b1; Lb = 1'b1; end
            default: ;
          endcase
        end
        T6: begin
          if (opcode == OP_ADD || opcode == OP_SUB) begin
            Eu = 1'b1;
            La = 1'b1;
            Su = (opcode == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

  assign tstate = state_q;
  assign halted = halted_q;

endmodule

// File: tb/tb_cpu_controller.sv
// tb/tb_cpu_controller.sv - random and directed checks of cpu_controller against an instruction-level model
module tb_cpu_controller;

  localparam logic [12:0] CP = 13'h1000, EP = 13'h0800, LP = 13'h0400, LM = 13'h0200;
  localparam logic [12:0] CE = 13'h0100, LI = 13'h0080, EI = 13'h0040, LA = 13'h0020;
  localparam logic [12:0] EA = 13'h0010, SU = 13'h0008, EU = 13'h0004, LB = 13'h0002;
  localparam logic [12:0] LO = 13'h0001;

  logic clk = 1'b0;
  logic clr = 1'b0;
  logic [3:0] op_a = 4'd0, op_b = 4'd0;
  logic z_a = 1'b0, z_b = 1'b0;

  logic [5:0] a_tstate, b_tstate;
  logic a_cp, a_ep, a_lp, a_lm, a_ce, a_li, a_ei, a_la, a_ea, a_su, a_eu, a_lb, a_lo, a_halted;
  logic b_cp, b_ep, b_lp, b_lm, b_ce, b_li, b_ei, b_la, b_ea, b_su, b_eu, b_lb, b_lo, b_halted;

  int total = 0;
  int bad = 0;

  // model state, index 0 = slow instance, 1 = FAST_NOP instance
  int         st[2];
  bit         hlt[2];
  bit         pick[2];
  logic [3:0] mop[2];
  logic       mz[2];
  logic [4:0] q_a[$];
  logic [4:0] q_b[$];

  cpu_controller #(.FAST_NOP(1'b0)) dut_a (
    .clk(clk), .clr(clr), .opcode(op_a), .zero_flag(z_a), .tstate(a_tstate),
    .Cp(a_cp), .Ep(a_ep), .Lp(a_lp), .Lm(a_lm), .Ce(a_ce), .Li(a_li), .Ei(a_ei),
    .La(a_la), .Ea(a_ea), .Su(a_su), .Eu(a_eu), .Lb(a_lb), .Lo(a_lo), .halted(a_halted)
  );

  cpu_controller #(.FAST_NOP(1'b1)) dut_b (
    .clk(clk), .clr(clr), .opcode(op_b), .zero_flag(z_b), .tstate(b_tstate),
    .Cp(b_cp), .Ep(b_ep), .Lp(b_lp), .Lm(b_lm), .Ce(b_ce), .Li(b_li), .Ei(b_ei),
    .La(b_la), .Ea(b_ea), .Su(b_su), .Eu(b_eu), .Lb(b_lb), .Lo(b_lo), .halted(b_halted)
  );

  always #5 clk = ~clk;

  function automatic logic [12:0] exp_ctrl(int s, logic [3:0] op, logic z);
    logic [12:0] w;
    w = 13'h0;
    case (s)
      1: w = EP | LM;
      2: w = CP;
      3: w = CE | LI;
      4: case (op)
           4'd0, 4'd1, 4'd2: w = EI | LM;
           4'd3:  w = EI | LP;
           4'd4:  w = z ? (EI | LP) : 13'h0;
           4'd14: w = EA | LO;
           default: w = 13'h0;
         endcase
      5: case (op)
           4'd0: w = CE | LA;
           4'd1, 4'd2: w = CE | LB;
           default: w = 13'h0;
         endcase
      6: case (op)
           4'd1: w = EU | LA;
           4'd2: w = EU | LA | SU;
           default: w = 13'h0;
         endcase
      default: w = 13'h0;
    endcase
    return w;
  endfunction

  function automatic int instr_len(logic [3:0] op, bit fast);
    if (!fast) return 6;
    if (op == 4'd0) return 5;
    if (op == 4'd1 || op == 4'd2) return 6;
    return 4;
  endfunction

  task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string where);
    logic [12:0] ow;
    logic [12:0] ew;
    logic [5:0]  ot;
    logic [5:0]  et;
    logic        oh;
    logic [4:0]  bus;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) begin
        ow = {a_cp, a_ep, a_lp, a_lm, a_ce, a_li, a_ei, a_la, a_ea, a_su, a_eu, a_lb, a_lo};
        ot = a_tstate; oh = a_halted; bus = {a_ep, a_ce, a_ei, a_ea, a_eu};
      end else begin
        ow = {b_cp, b_ep, b_lp, b_lm, b_ce, b_li, b_ei, b_la, b_ea, b_su, b_eu, b_lb, b_lo};
        ot = b_tstate; oh = b_halted; bus = {b_ep, b_ce, b_ei, b_ea, b_eu};
      end
      et = 6'(1 << (st[k] - 1));
      ew = (clr || hlt[k]) ? 13'h0 : exp_ctrl(st[k], mop[k], mz[k]);
      chk($sformatf("%s_tstate_%0d", where, k), {10'd0, ot}, {10'd0, et});
      chk($sformatf("%s_halted_%0d", where, k), {15'd0, oh}, {15'd0, hlt[k]});
      chk($sformatf("%s_ctrl_%0d_op%0d_t%0d", where, k, mop[k], st[k]), {3'd0, ow}, {3'd0, ew});
      chk($sformatf("%s_busexcl_%0d", where, k), {15'd0, $onehot0(bus)}, 16'd1);
    end
  endtask

  task automatic load(int k);
    logic [4:0] e;
    if (k == 0 && q_a.size() > 0) e = q_a.pop_front();
    else if (k == 1 && q_b.size() > 0) e = q_b.pop_front();
    else e = {1'($urandom_range(0, 1)), 4'($urandom_range(0, 14))};
    mop[k] = e[3:0];
    mz[k]  = e[4];
    pick[k] = 1'b0;
    if (k == 0) begin op_a = e[3:0]; z_a = e[4]; end
    else begin op_b = e[3:0]; z_b = e[4]; end
  endtask

  task automatic advance(int k);
    if (clr) begin
      st[k] = 1; hlt[k] = 1'b0;
    end else if (hlt[k]) begin
      st[k] = st[k];
    end else if (st[k] == 4 && mop[k] == 4'd15) begin
      hlt[k] = 1'b1;
    end else if (st[k] == instr_len(mop[k], k == 1)) begin
      st[k] = 1; pick[k] = 1'b1;
    end else begin
      st[k] = st[k] + 1;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_all("cyc");
    @(posedge clk);
    advance(0);
    advance(1);
    #1;
    if (pick[0]) load(0);
    if (pick[1]) load(1);
  endtask

  // clr rises now (between edges); outputs must react before any clock edge
  task automatic reset_pulse(int ncyc);
    clr = 1'b1;
    for (int k = 0; k < 2; k++) begin st[k] = 1; hlt[k] = 1'b0; pick[k] = 1'b0; end
    #1;
    check_all("clr_async");
    repeat (ncyc) tick();
    clr = 1'b0;
    load(0);
    load(1);
  endtask

  initial begin
    bit found;
    for (int k = 0; k < 2; k++) begin st[k] = 1; hlt[k] = 1'b0; pick[k] = 1'b0; mop[k] = 4'd0; mz[k] = 1'b0; end

    q_a.push_back({1'b0, 4'd1});
    q_a.push_back({1'b0, 4'd2});
    q_a.push_back({1'b1, 4'd4});
    q_a.push_back({1'b0, 4'd4});
    q_a.push_back({1'b0, 4'd0});
    q_a.push_back({1'b0, 4'd14});
    q_a.push_back({1'b0, 4'd3});
    q_a.push_back({1'b1, 4'd7});
    q_b.push_back({1'b0, 4'd14});
    q_b.push_back({1'b0, 4'd0});
    q_b.push_back({1'b0, 4'd1});
    q_b.push_back({1'b1, 4'd2});
    q_b.push_back({1'b1, 4'd4});
    q_b.push_back({1'b0, 4'd4});
    q_b.push_back({1'b0, 4'd9});

    #3;
    reset_pulse(3);
    repeat (60) tick();

    q_a.push_back({1'b0, 4'd0});
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      tick();
      if (st[0] == 5 && mop[0] == 4'd0) found = 1'b1;
    end
    chk("reach_lda_t5", {15'd0, found}, 16'd1);
    #2;
    reset_pulse(1);
    repeat (12) tick();

    q_a.push_back({1'b0, 4'd15});
    q_b.push_back({1'b0, 4'd15});
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (hlt[0] && hlt[1]) found = 1'b1;
    end
    chk("reach_halt", {15'd0, found}, 16'd1);
    repeat (20) tick();
    #2;
    reset_pulse(2);

    repeat (300) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_controller.md
# cpu_controller

Control sequencer for the 4-bit CPU. It runs a six-state one-hot ring counter (T1..T6) and decodes the instruction register opcode into the datapath control word. That control word drives the program counter (count enable, output enable, load), MAR, RAM, IR, accumulator, B register, ALU and output register. It is the only block that sequences `programCounter`, and it owns instruction fetch, execute and halt.

## Interface
- `FAST_NOP`, default 0: when 1, an instruction returns to T1 right after its last active T-state; when 0, every instruction takes all 6 T-states.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `clr`  in  1  reset, asynchronous, active-high.
- `opcode`  in  4  IR[7:4]; valid from T4 onward.
- `zero_flag`  in  1  accumulator == 0; sampled combinationally in T4.
- `tstate`  out  6  one-hot ring state, bit0 = T1.
- `Cp`  out  1  PC count enable.
- `Ep`  out  1  PC drives bus.
- `Lp`  out  1  PC loads from bus (jump).
- `Lm`  out  1  MAR load.
- `Ce`  out  1  RAM drives bus.
- `Li`  out  1  IR load.
- `Ei`  out  1  IR operand (IR[3:0]) drives bus.
- `La`  out  1  accumulator load.
- `Ea`  out  1  accumulator drives bus.
- `Su`  out  1  ALU subtract select.
- `Eu`  out  1  ALU drives bus.
- `Lb`  out  1  B register load.
- `Lo`  out  1  output register load.
- `halted`  out  1  HLT executed; the CPU is frozen.

## Operation
- Ring counter: one-hot `tstate`. It advances T1→T2→…→T6→T1 on each rising edge of `clk`, except when halted.
- Control word: combinational decode of `tstate`, `opcode` and `zero_flag`. Every control output is forced to 0 while `clr`=1 or `halted`=1.
- Fetch, common to all opcodes:
  - T1: `Ep`, `Lm`
  - T2: `Cp`
  - T3: `Ce`, `Li`
- Execute, by opcode:
  - LDA 0000: T4 `Ei`,`Lm`; T5 `Ce`,`La`; T6 none.
  - ADD 0001: T4 `Ei`,`Lm`; T5 `Ce`,`Lb`; T6 `Eu`,`La`.
  - SUB 0010: same as ADD, plus `Su` in T6.
  - JMP 0011: T4 `Ei`,`Lp`.
  - JZ 0100: T4 `Ei`,`Lp` only if `zero_flag`=1; otherwise no controls.
  - OUT 1110: T4 `Ea`,`Lo`.
  - HLT 1111: T4 no controls. The T4 rising edge sets `halted`=1.
  - Any other opcode: NOP, no controls in T4..T6.
- `FAST_NOP`=1, last active state of each instruction:
  - LDA ends after T5.
  - JMP, JZ, OUT and NOP end after T4.
  - ADD and SUB still use T6.
  - Ending after state Tn means the edge that would enter Tn+1 enters T1 instead.
- Halt:
  - `halted` is set on the rising edge at the end of T4 of an HLT instruction. On that same edge `tstate` is held at T4 and does not advance to T5 or T1.
  - `halted` is sticky. Only `clr` clears it.
- Mutual exclusion: at most one bus driver (`Ep`, `Ce`, `Ei`, `Ea`, `Eu`) is asserted in any cycle. Verification checks this with an assertion.

## Timing
- Reset state, asynchronous on `clr`=1:
  - `tstate`=000001 (T1), `halted`=0.
  - All control outputs are 0 for as long as `clr` is high.
- On `clr` deassertion, the cycle before the first rising edge is T1 with `Ep`,`Lm`=1. That first edge loads the PC value into MAR.
- The datapath acts on the rising edge that ends a T-state, using the control word held during that state.
- The control word changes only after a `clk` rising edge or a `clr` change. There are no glitches from `opcode` changes during T1..T3: `opcode` affects outputs only in T4..T6.
- Instruction length:
  - `FAST_NOP`=0: 6 cycles per instruction.
  - `FAST_NOP`=1: LDA 5 cycles; ADD and SUB 6 cycles; others 4 cycles.
- `zero_flag` must be stable throughout T4. Lp follows it combinationally during T4.
- `clr` asserted mid-instruction: the ring returns to T1 immediately and `halted` clears. The partially executed instruction is abandoned and has no further effect.

## Test plan
- **Reset:** hold `clr`=1 for 3 cycles → all controls 0 and `tstate`=000001. On release, cycle 1 shows `Ep`=`Lm`=1, then cycle 2 `Cp`=1, then cycle 3 `Ce`=`Li`=1.
- **ADD and SUB:**
  - `opcode`=0001 → T4 `Ei`,`Lm`; T5 `Ce`,`Lb`; T6 `Eu`,`La` with `Su`=0, then back to T1.
  - `opcode`=0010 → same sequence with `Su`=1 in T6.
- **JZ:**
  - `opcode`=0100 with `zero_flag`=1 → `Lp`=`Ei`=1 in T4.
  - `opcode`=0100 with `zero_flag`=0 → no controls in T4.
- **HLT:** `opcode`=1111 → `halted`=1 after the T4 edge. `tstate` then stays 001000 and all controls stay 0 for 20 cycles. Pulsing `clr` → T1, `halted`=0.
- **Reset mid-instruction:** assert `clr` asynchronously mid-T5 of LDA → `tstate`=000001 and `La`=0 at once, with no wait for a clock edge.
- **`FAST_NOP`=1:**
  - OUT → T1 follows T4.
  - LDA → T1 follows T5.
  - ADD → all six states.
